// File: rtl/fm_post_decimator.sv
// Boxcar accumulate-and-dump decimator for the FM demodulator frequency stream.
// Build option: define FM_POST_DECIM_ROUND_EN for round-half-up instead of floor.
module fm_post_decimator #(
    parameter int IN_W       = 18,
    parameter int LOG2_DECIM = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    output logic [IN_W-1:0]       out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  ov_clr,
    output logic                  overrun,
    output logic [LOG2_DECIM-1:0] phase
);

    localparam int ACC_W = IN_W + LOG2_DECIM + 1;
    localparam logic [LOG2_DECIM-1:0] PHASE_LAST = '1;
`ifdef FM_POST_DECIM_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(2 ** (LOG2_DECIM - 1));
`endif

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LOG2_DECIM-1:0]    phase_q, phase_d;
    logic [IN_W-1:0]          out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;

    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  rounded;
    logic                     block_done;
    logic                     ov_event;

    always_comb begin
        in_ext     = {{(LOG2_DECIM + 1){in_data[IN_W-1]}}, in_data};
        sum        = acc_q + in_ext;
`ifdef FM_POST_DECIM_ROUND_EN
        rounded    = sum + ROUND_HALF;
`else
        rounded    = sum;
`endif
        block_done = in_valid && (phase_q == PHASE_LAST);
        // A new result only counts as lost if the pending one is not leaving this cycle.
        ov_event   = block_done && out_valid_q && !out_ready;

        acc_d       = acc_q;
        phase_d     = phase_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (in_valid) begin
            if (block_done) begin
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + 1'b1;
            end
        end

        if (block_done) begin
            out_data_d  = IN_W'(rounded >>> LOG2_DECIM);
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (ov_event) begin
            overrun_d = 1'b1;
        end else if (ov_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            phase_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_fm_post_decimator.sv
// Directed bench for fm_post_decimator (IN_W=18, LOG2_DECIM=3).
module tb_fm_post_decimator;

    logic        clk;
    logic        reset;
    logic [17:0] in_data;
    logic        in_valid;
    logic [17:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        ov_clr;
    logic        overrun;
    logic [2:0]  phase;

    int check_cnt = 0;
    int pass_cnt  = 0;

    fm_post_decimator #(.IN_W(18), .LOG2_DECIM(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ov_clr    (ov_clr),
        .overrun   (overrun),
        .phase     (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %s got=%0d", tag, got);
        end else begin
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 18'(v);
            tick();
        end
        in_valid = 1'b0;
    endtask

    int exp_pos4;
    int exp_neg4;

    initial begin
`ifdef FM_POST_DECIM_ROUND_EN
        exp_pos4 = 1;
        exp_neg4 = 0;
`else
        exp_pos4 = 0;
        exp_neg4 = -1;
`endif
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ov_clr    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_data", $signed(out_data), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_phase", int'(phase), 0);

        // Basic average with phase tracking
        feed(1000, 3);
        check("b1000_phase3", int'(phase), 3);
        check("b1000_novalid", int'(out_valid), 0);
        feed(1000, 5);
        check("b1000_valid", int'(out_valid), 1);
        check("b1000_data", $signed(out_data), 1000);
        check("b1000_phase0", int'(phase), 0);
        tick();
        check("b1000_drained", int'(out_valid), 0);

        // Rounding boundary
        feed(0, 7);
        feed(4, 1);
        check("pos4_data", $signed(out_data), exp_pos4);
        feed(0, 7);
        feed(-4, 1);
        check("neg4_data", $signed(out_data), exp_neg4);

        // Extremes
        feed(131071, 8);
        check("max_data", $signed(out_data), 131071);
        feed(-131072, 8);
        check("min_data", $signed(out_data), -131072);
        tick();

        // Gapped input: phase holds on idle cycles
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 18'(-500);
            tick();
            if (i == 5) check("gap_phase_hold", int'(phase), 3);
            if (i == 13) check("gap_novalid", int'(out_valid), 0);
        end
        in_valid = 1'b0;
        check("gap_data", $signed(out_data), -500);
        check("gap_valid", int'(out_valid), 0);

        // Stalled sink: overrun and clear
        out_ready = 1'b0;
        feed(10, 8);
        check("stall10_data", $signed(out_data), 10);
        check("stall10_ov", int'(overrun), 0);
        tick();
        tick();
        check("stall10_hold", $signed(out_data), 10);
        check("stall10_vhold", int'(out_valid), 1);
        feed(20, 8);
        check("stall20_data", $signed(out_data), 20);
        check("stall20_ov", int'(overrun), 1);
        ov_clr = 1'b1;
        tick();
        ov_clr = 1'b0;
        check("ovclr", int'(overrun), 0);
        check("ovclr_valid", int'(out_valid), 1);
        feed(30, 7);
        ov_clr = 1'b1;
        feed(30, 1);
        ov_clr = 1'b0;
        check("ov_wins_clr", int'(overrun), 1);
        check("ov_wins_data", $signed(out_data), 30);
        ov_clr = 1'b1;
        tick();
        ov_clr = 1'b0;
        check("ovclr2", int'(overrun), 0);

        // New result with sink ready in the same cycle: no overrun
        feed(40, 7);
        out_ready = 1'b1;
        feed(40, 1);
        check("sim_valid", int'(out_valid), 1);
        check("sim_data", $signed(out_data), 40);
        check("sim_ov", int'(overrun), 0);
        tick();
        check("sim_drained", int'(out_valid), 0);

        // Reset mid-block with a pending result
        out_ready = 1'b0;
        feed(50, 8);
        feed(0, 7);
        feed(-8, 1);
        feed(300, 5);
        check("pre_rst_ov", int'(overrun), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_data", $signed(out_data), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_ov", int'(overrun), 0);
        check("mid_rst_phase", int'(phase), 0);
        out_ready = 1'b1;
        feed(7, 8);
        check("post_rst_valid", int'(out_valid), 1);
        check("post_rst_data", $signed(out_data), 7);
        tick();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
